// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: bundles the next-PC, instruction-memory and decode-side
// signals of the program-counter / fetch sequencer.
//   master : the fetch unit itself
//   slave  : the surrounding core (next-PC logic, instruction memory, decode)
interface pc_fetch_unit_if;
  logic [63:0] next_pc;
  logic [63:0] current_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_taken;
  logic [63:0] retire_count;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  modport master (
    input  next_pc, imem_ack, imem_data, instr_taken,
    output current_pc, imem_req, imem_addr, instruction, instr_valid,
           retire_count, fetch_fault, fault_cause
  );

  modport slave (
    output next_pc, imem_ack, imem_data, instr_taken,
    input  current_pc, imem_req, imem_addr, instruction, instr_valid,
           retire_count, fetch_fault, fault_cause
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Holds the current PC, fetches the word at that PC over a req/ack handshake,
// presents it to decode and commits the next PC when decode takes it.
// A request that waits TIMEOUT cycles without an ack raises a sticky fault;
// only reset leaves the fault state.
// Optional feature macro: PC_ALIGN_CHECK_EN -- when defined, committing a
// next PC whose low two bits are non-zero raises a misalignment fault
// instead of issuing the next fetch.
// CNT_W must satisfy 2**CNT_W > TIMEOUT, and TIMEOUT must be at least 1.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       CAUSE_TMO   = 2'b01;
  localparam logic [1:0]       CAUSE_ALIGN = 2'b10;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] timeout_cnt;
  logic [63:0]      current_pc;
  logic [31:0]      instruction;
  logic             instr_valid;
  logic [63:0]      retire_count;
  logic             fetch_fault;
  logic [1:0]       fault_cause;

  logic load_instr;
  logic commit;
  logic raise_timeout;
  logic raise_align;

  // State register; reset restarts fetching from S_REQ and abandons any open request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and the one-cycle event strobes that drive the datapath
  always_comb begin
    state_d       = state_q;
    load_instr    = 1'b0;
    commit        = 1'b0;
    raise_timeout = 1'b0;
    raise_align   = 1'b0;
    case (state_q)
      S_REQ: begin
        if (bus.imem_ack) begin
          load_instr = 1'b1;
          state_d    = S_VALID;
        end else if (timeout_cnt == CNT_LAST) begin
          raise_timeout = 1'b1;
          state_d       = S_FAULT;
        end
      end
      S_VALID: begin
        if (bus.instr_taken) begin
          commit  = 1'b1;
          state_d = S_REQ;
`ifdef PC_ALIGN_CHECK_EN
          if (bus.next_pc[1:0] != 2'b00) begin
            raise_align = 1'b1;
            state_d     = S_FAULT;
          end
`endif
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Datapath: timeout counter, PC, fetched word, retire counter and sticky fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt  <= '0;
      current_pc   <= RESET_PC;
      instruction  <= 32'h0;
      instr_valid  <= 1'b0;
      retire_count <= 64'h0;
      fetch_fault  <= 1'b0;
      fault_cause  <= 2'b00;
    end else begin
      if (load_instr) begin
        timeout_cnt <= '0;
      end else if (state_q == S_REQ) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end

      if (load_instr) begin
        instruction <= bus.imem_data;
        instr_valid <= 1'b1;
      end

      if (commit) begin
        current_pc   <= bus.next_pc;
        retire_count <= retire_count + 64'd1;
        instr_valid  <= 1'b0;
      end

      if (raise_timeout) begin
        fetch_fault <= 1'b1;
        fault_cause <= CAUSE_TMO;
      end else if (raise_align) begin
        fetch_fault <= 1'b1;
        fault_cause <= CAUSE_ALIGN;
      end
    end
  end

  // The request is held low for as long as reset is asserted
  assign bus.imem_req     = (state_q == S_REQ) && rst_n;
  assign bus.imem_addr    = current_pc;
  assign bus.current_pc   = current_pc;
  assign bus.instruction  = instruction;
  assign bus.instr_valid  = instr_valid;
  assign bus.retire_count = retire_count;
  assign bus.fetch_fault  = fetch_fault;
  assign bus.fault_cause  = fault_cause;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit with
// RESET_PC=64'h100 and TIMEOUT=16. Honours PC_ALIGN_CHECK_EN when defined.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC (64'h100),
    .TIMEOUT  (16),
    .CNT_W    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.next_pc      = 64'h0;
    bus.imem_ack     = 1'b0;
    bus.imem_data    = 32'h0;
    bus.instr_taken  = 1'b0;
    tick();
    tick();
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req actual=%b expected=0", bus.imem_req); end
    checks++;
    if (bus.current_pc !== 64'h100) begin errors++; $display("[TB] FAIL rst_pc actual=%h expected=100", bus.current_pc); end
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instruction !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_instr actual=%b/%h expected=0/0", bus.instr_valid, bus.instruction);
    end
    checks++;
    if (bus.retire_count !== 64'h0) begin errors++; $display("[TB] FAIL rst_retire actual=%h expected=0", bus.retire_count); end
    checks++;
    if (bus.fetch_fault !== 1'b0 || bus.fault_cause !== 2'b00) begin
      errors++; $display("[TB] FAIL rst_fault actual=%b/%b expected=0/00", bus.fetch_fault, bus.fault_cause);
    end
    checks++;
    rst_n = 1'b1;
    #1;
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rel_req actual=%b expected=1", bus.imem_req); end
    checks++;
    if (bus.imem_addr !== 64'h100) begin errors++; $display("[TB] FAIL rel_addr actual=%h expected=100", bus.imem_addr); end
    checks++;
  endtask

  task automatic test_fetch_commit();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'h8B020020;
    tick();
    bus.imem_ack  = 1'b0;
    if (bus.instruction !== 32'h8B020020) begin errors++; $display("[TB] FAIL fc_instr actual=%h expected=8b020020", bus.instruction); end
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL fc_valid actual=%b/%b expected=1/0", bus.instr_valid, bus.imem_req);
    end
    checks++;
    bus.instr_taken = 1'b1;
    bus.next_pc     = 64'h104;
    tick();
    bus.instr_taken = 1'b0;
    chk64("fc_pc", bus.current_pc, 64'h104);
    chk64("fc_retire", bus.retire_count, 64'd1);
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL fc_next actual=%b/%b expected=0/1", bus.instr_valid, bus.imem_req);
    end
    checks++;
    chk64("fc_addr", bus.imem_addr, 64'h104);
  endtask

  task automatic test_hold();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'hD503201F;
    tick();
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'hFFFFFFFF;
    bus.next_pc   = 64'h200;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.instr_valid !== 1'b1 || bus.instruction !== 32'hD503201F ||
          bus.imem_req !== 1'b0 || bus.current_pc !== 64'h104) begin
        errors++;
        $display("[TB] FAIL hold_%0d actual=%b/%h/%b/%h expected=1/d503201f/0/104",
                 i, bus.instr_valid, bus.instruction, bus.imem_req, bus.current_pc);
      end
      checks++;
    end
    bus.instr_taken = 1'b1;
    bus.next_pc     = 64'h108;
    tick();
    bus.instr_taken = 1'b0;
    chk64("hold_pc", bus.current_pc, 64'h108);
    chk64("hold_retire", bus.retire_count, 64'd2);
  endtask

  task automatic test_ack_at_timeout();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL edge_pre actual=%b/%b expected=0/1", bus.fetch_fault, bus.imem_req);
    end
    checks++;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'h11111111;
    tick();
    bus.imem_ack  = 1'b0;
    if (bus.fetch_fault !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instruction !== 32'h11111111) begin
      errors++; $display("[TB] FAIL edge_ack actual=%b/%b/%h expected=0/1/11111111",
                         bus.fetch_fault, bus.instr_valid, bus.instruction);
    end
    checks++;
    bus.instr_taken = 1'b1;
    bus.next_pc     = 64'h10C;
    tick();
    bus.instr_taken = 1'b0;
    chk64("edge_retire", bus.retire_count, 64'd3);
  endtask

  task automatic test_timeout();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL tmo_pre actual=%b/%b expected=0/1", bus.fetch_fault, bus.imem_req);
    end
    checks++;
    tick();
    if (bus.fetch_fault !== 1'b1 || bus.fault_cause !== 2'b01 || bus.imem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL tmo_fault actual=%b/%b/%b expected=1/01/0",
                         bus.fetch_fault, bus.fault_cause, bus.imem_req);
    end
    checks++;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'h22222222;
    tick();
    tick();
    bus.imem_ack  = 1'b0;
    if (bus.instr_valid !== 1'b0 || bus.instruction !== 32'h11111111 || bus.imem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL tmo_late_ack actual=%b/%h/%b expected=0/11111111/0",
                         bus.instr_valid, bus.instruction, bus.imem_req);
    end
    checks++;
    chk64("tmo_pc", bus.current_pc, 64'h10C);
    rst_n = 1'b0;
    #1;
    if (bus.fetch_fault !== 1'b0 || bus.fault_cause !== 2'b00) begin
      errors++; $display("[TB] FAIL tmo_clear actual=%b/%b expected=0/00", bus.fetch_fault, bus.fault_cause);
    end
    checks++;
    chk64("tmo_rst_pc", bus.current_pc, 64'h100);
    tick();
    rst_n = 1'b1;
    #1;
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL tmo_rereq actual=%b expected=1", bus.imem_req); end
    checks++;
  endtask

  task automatic test_align();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'h33333333;
    tick();
    bus.imem_ack    = 1'b0;
    bus.instr_taken = 1'b1;
    bus.next_pc     = 64'h106;
    tick();
    bus.instr_taken = 1'b0;
    chk64("al_pc", bus.current_pc, 64'h106);
    chk64("al_retire", bus.retire_count, 64'd1);
`ifdef PC_ALIGN_CHECK_EN
    if (bus.fetch_fault !== 1'b1 || bus.fault_cause !== 2'b10 || bus.imem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL al_fault actual=%b/%b/%b expected=1/10/0",
                         bus.fetch_fault, bus.fault_cause, bus.imem_req);
    end
    checks++;
    tick();
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL al_noreq actual=%b expected=0", bus.imem_req); end
    checks++;
`else
    if (bus.fetch_fault !== 1'b0 || bus.fault_cause !== 2'b00 || bus.imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL al_fetch actual=%b/%b/%b expected=0/00/1",
                         bus.fetch_fault, bus.fault_cause, bus.imem_req);
    end
    checks++;
    chk64("al_addr", bus.imem_addr, 64'h106);
`endif
  endtask

  // Scenario sequence
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch_commit();
    test_hold();
    test_ack_at_timeout();
    test_timeout();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
